// File: rtl/ccu_snoop_fanout.sv
// ACE snoop fan-out: broadcasts one AC to the masked cached masters, merges their CRs and
// forwards CD from a single responder. Optional counters behind CCU_SNOOP_FANOUT_STATS_EN.

package ccu_snoop_fanout_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  prot;
    } ac_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } cd_chan_t;

    typedef struct packed {
        ac_chan_t ac;
        logic     ac_valid;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        logic [4:0] cr_resp;
        logic     cd_valid;
        cd_chan_t cd;
    } snoop_resp_t;

    // CR bit positions: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    localparam int unsigned CrDataTransfer = 0;
    localparam int unsigned CrError        = 1;
    localparam int unsigned CrPassDirty    = 2;
    localparam int unsigned CrIsShared     = 3;
    localparam int unsigned CrWasUnique    = 4;

endpackage

module ccu_snoop_fanout
    import ccu_snoop_fanout_pkg::*;
#(
    parameter int unsigned NoMstPorts    = 4,
    parameter type         domain_mask_t = logic [NoMstPorts-1:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  snoop_req_t                   slv_snoop_req_i,
    output snoop_resp_t                  slv_snoop_resp_o,
    input  domain_mask_t                 slv_mask_i,
    output snoop_req_t  [NoMstPorts-1:0] mst_snoop_reqs_o,
    input  snoop_resp_t [NoMstPorts-1:0] mst_snoop_resps_i,
    output logic                         busy_o
`ifdef CCU_SNOOP_FANOUT_STATS_EN
    ,
    output logic [31:0]                  snoop_cnt_o,
    output logic [31:0]                  data_cnt_o
`endif
);

    localparam int unsigned SelW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BCAST,
        RESP,
        DATA
    } state_e;

    state_e                          state_q, state_d;
    ac_chan_t                        ac_q;
    logic [NoMstPorts-1:0]           mask_q;
    logic [NoMstPorts-1:0]           ac_acked_q, ac_acked_d;
    logic [NoMstPorts-1:0]           cr_got_q, cr_got_d;
    logic [NoMstPorts-1:0][4:0]      cr_regs_q, cr_regs_d;
    logic [SelW-1:0]                 sel_q, sel_d;
    logic [NoMstPorts-1:0]           drain_q, drain_d;
    logic                            sel_done_q, sel_done_d;

    logic                            latch_ac;
    logic                            resp_fire;
    logic                            sel_cd_valid;
    logic [4:0]                      merged;
    logic [SelW-1:0]                 sel_c;
    logic                            sel_found;
    logic [NoMstPorts-1:0]           dt_vec;
    logic [NoMstPorts-1:0]           sel_onehot;

    // Merged CR plus the data-source choice, derived from the stored per-port responses
    always_comb begin
        merged     = '0;
        sel_c      = '0;
        sel_found  = 1'b0;
        dt_vec     = '0;
        sel_onehot = '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            if (mask_q[i]) begin
                merged    = merged | cr_regs_q[i];
                dt_vec[i] = cr_regs_q[i][CrDataTransfer];
                if (cr_regs_q[i][CrDataTransfer] && !sel_found) begin
                    sel_c     = SelW'(i);
                    sel_found = 1'b1;
                end
            end
        end
        sel_onehot[sel_c] = sel_found;
    end

    always_comb begin
        state_d          = state_q;
        ac_acked_d       = ac_acked_q;
        cr_got_d         = cr_got_q;
        cr_regs_d        = cr_regs_q;
        sel_d            = sel_q;
        drain_d          = drain_q;
        sel_done_d       = sel_done_q;
        latch_ac         = 1'b0;
        resp_fire        = 1'b0;
        sel_cd_valid     = 1'b0;
        slv_snoop_resp_o = '0;
        mst_snoop_reqs_o = '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            mst_snoop_reqs_o[i].ac = ac_q;
        end

        unique case (state_q)
            IDLE: begin
                // ac_ready is gated so every handshake output reads 0 while reset is held
                slv_snoop_resp_o.ac_ready = rst_ni;
                if (slv_snoop_req_i.ac_valid) begin
                    latch_ac   = 1'b1;
                    ac_acked_d = '0;
                    cr_got_d   = '0;
                    cr_regs_d  = '0;
                    sel_d      = '0;
                    drain_d    = '0;
                    sel_done_d = 1'b0;
                    state_d    = (slv_mask_i == '0) ? RESP : BCAST;
                end
            end

            BCAST: begin
                for (int i = 0; i < NoMstPorts; i++) begin
                    mst_snoop_reqs_o[i].ac_valid = mask_q[i] & ~ac_acked_q[i];
                    mst_snoop_reqs_o[i].cr_ready = mask_q[i] & ac_acked_q[i] & ~cr_got_q[i];
                    if (mask_q[i] && !ac_acked_q[i] && mst_snoop_resps_i[i].ac_ready) begin
                        ac_acked_d[i] = 1'b1;
                    end
                    if (mask_q[i] && ac_acked_q[i] && !cr_got_q[i] &&
                        mst_snoop_resps_i[i].cr_valid) begin
                        cr_got_d[i]  = 1'b1;
                        cr_regs_d[i] = mst_snoop_resps_i[i].cr_resp;
                    end
                end
                if (&(cr_got_q | ~mask_q)) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                slv_snoop_resp_o.cr_valid = 1'b1;
                slv_snoop_resp_o.cr_resp  = merged;
                if (slv_snoop_req_i.cr_ready) begin
                    resp_fire = 1'b1;
                    if (merged[CrDataTransfer]) begin
                        state_d    = DATA;
                        sel_d      = sel_c;
                        drain_d    = dt_vec & ~sel_onehot;
                        sel_done_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                sel_cd_valid              = mst_snoop_resps_i[sel_q].cd_valid & ~sel_done_q;
                slv_snoop_resp_o.cd_valid = sel_cd_valid;
                slv_snoop_resp_o.cd       = mst_snoop_resps_i[sel_q].cd;
                if (!sel_done_q) begin
                    mst_snoop_reqs_o[sel_q].cd_ready = slv_snoop_req_i.cd_ready;
                end
                if (sel_cd_valid && slv_snoop_req_i.cd_ready &&
                    mst_snoop_resps_i[sel_q].cd.last) begin
                    sel_done_d = 1'b1;
                end
                // Drained ports are always ready; their beats never reach the slave side
                for (int j = 0; j < NoMstPorts; j++) begin
                    if (drain_q[j]) begin
                        mst_snoop_reqs_o[j].cd_ready = 1'b1;
                        if (mst_snoop_resps_i[j].cd_valid && mst_snoop_resps_i[j].cd.last) begin
                            drain_d[j] = 1'b0;
                        end
                    end
                end
                if (sel_done_d && (drain_d == '0)) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ac_q       <= '0;
            mask_q     <= '0;
            ac_acked_q <= '0;
            cr_got_q   <= '0;
            cr_regs_q  <= '0;
            sel_q      <= '0;
            drain_q    <= '0;
            sel_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ac_acked_q <= ac_acked_d;
            cr_got_q   <= cr_got_d;
            cr_regs_q  <= cr_regs_d;
            sel_q      <= sel_d;
            drain_q    <= drain_d;
            sel_done_q <= sel_done_d;
            if (latch_ac) begin
                ac_q   <= slv_snoop_req_i.ac;
                mask_q <= slv_mask_i;
            end
        end
    end

    assign busy_o = (state_q != IDLE);

`ifdef CCU_SNOOP_FANOUT_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snoop_cnt_o <= '0;
            data_cnt_o  <= '0;
        end else begin
            if (latch_ac) begin
                snoop_cnt_o <= snoop_cnt_o + 32'd1;
            end
            if (resp_fire && merged[CrDataTransfer]) begin
                data_cnt_o <= data_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
